// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, zero word and debug FSM state encodings for the register file
package regfile_pkg;
  localparam int REG_NUM = 32;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ACK = 2'd2;
endpackage

// File: rtl/regfile_dbg_ctrl.sv
// regfile_dbg_ctrl: debug req/ack FSM that yields the write port to write-back and registers read data and ack
module regfile_dbg_ctrl
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              wb_we,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dbg_wr_en,
  output logic [ADDR_W-1:0] dbg_wr_addr,
  output logic [DATA_W-1:0] dbg_wr_data,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack
);
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       access;
  logic       stall;
  assign access = state == ACCESS;
  assign stall = dbg_we && wb_we;
  assign state_nxt = state == IDLE ? (dbg_req ? ACCESS : IDLE) : access ? (stall ? ACCESS : ACK) : IDLE;
  assign dbg_wr_en = access && dbg_we && !wb_we;
  assign dbg_wr_addr = dbg_addr;
  assign dbg_wr_data = dbg_wdata;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dbg_ack <= 1'b0;
      dbg_rdata <= ZERO_WORD;
    end else begin
      state <= state_nxt;
      dbg_ack <= access && !stall;
      if (access && !dbg_we) dbg_rdata <= rd_data;
    end
  end
endmodule

// File: rtl/regfile.sv
// regfile: 32x32 integer register file, x0 hardwired to zero, two read ports, debug port; define REGFILE_BYPASS_EN for write-back forwarding
module regfile
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_we_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs2_data_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o
);
`ifdef REGFILE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif
  logic [DATA_W-1:0] regs [REG_NUM];
  logic              wb_live;
  logic              dbg_wr_en;
  logic [ADDR_W-1:0] dbg_wr_addr;
  logic [DATA_W-1:0] dbg_wr_data;
  logic [DATA_W-1:0] dbg_rd;
  assign wb_live = BYPASS && rd_we_i && rd_addr_i != '0;
  assign rs1_data_o = rs1_addr_i == '0 ? ZERO_WORD : (wb_live && rd_addr_i == rs1_addr_i) ? rd_data_i : regs[rs1_addr_i];
  assign rs2_data_o = rs2_addr_i == '0 ? ZERO_WORD : (wb_live && rd_addr_i == rs2_addr_i) ? rd_data_i : regs[rs2_addr_i];
  assign dbg_rd = dbg_addr_i == '0 ? ZERO_WORD : (wb_live && rd_addr_i == dbg_addr_i) ? rd_data_i : regs[dbg_addr_i];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= ZERO_WORD;
    end else if (rd_we_i && rd_addr_i != '0) begin
      regs[rd_addr_i] <= rd_data_i;
    end else if (dbg_wr_en && dbg_wr_addr != '0) begin
      regs[dbg_wr_addr] <= dbg_wr_data;
    end
  end
  regfile_dbg_ctrl u_dbg_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .dbg_req    (dbg_req_i),
    .dbg_we     (dbg_we_i),
    .dbg_addr   (dbg_addr_i),
    .dbg_wdata  (dbg_wdata_i),
    .wb_we      (rd_we_i),
    .rd_data    (dbg_rd),
    .dbg_wr_en  (dbg_wr_en),
    .dbg_wr_addr(dbg_wr_addr),
    .dbg_wr_data(dbg_wr_data),
    .dbg_rdata  (dbg_rdata_o),
    .dbg_ack    (dbg_ack_o)
  );
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: randomized self-checking bench for regfile against an array reference model
module tb_regfile;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_we_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic [4:0]  rs1_addr_i;
  logic [31:0] rs1_data_o;
  logic [4:0]  rs2_addr_i;
  logic [31:0] rs2_data_o;
  logic        dbg_req_i;
  logic        dbg_we_i;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic [31:0] dbg_rdata_o;
  logic        dbg_ack_o;
  logic [31:0] model [32];
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;
  regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_we_i    (rd_we_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_i  (rd_data_i),
    .rs1_addr_i (rs1_addr_i),
    .rs1_data_o (rs1_data_o),
    .rs2_addr_i (rs2_addr_i),
    .rs2_data_o (rs2_data_o),
    .dbg_req_i  (dbg_req_i),
    .dbg_we_i   (dbg_we_i),
    .dbg_addr_i (dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i),
    .dbg_rdata_o(dbg_rdata_o),
    .dbg_ack_o  (dbg_ack_o)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && rd_we_i && rd_addr_i == a) return rd_data_i;
    return model[a];
  endfunction
  task automatic commit_wb();
    if (rd_we_i && rd_addr_i != 0) model[rd_addr_i] = rd_data_i;
  endtask
  task automatic check_reads(input string name);
    #1;
    vectors++;
    if (rs1_data_o !== exp_rd(rs1_addr_i)) begin
      errors++;
      $display("FAIL %s rs1[%0d] got %h expected %h", name, rs1_addr_i, rs1_data_o, exp_rd(rs1_addr_i));
    end
    vectors++;
    if (rs2_data_o !== exp_rd(rs2_addr_i)) begin
      errors++;
      $display("FAIL %s rs2[%0d] got %h expected %h", name, rs2_addr_i, rs2_data_o, exp_rd(rs2_addr_i));
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    dbg_req_i = 1'b0;
    rd_we_i = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask
  task automatic test_reset();
    do_reset();
    vectors++;
    if (dbg_ack_o !== 1'b0 || dbg_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_dbg ack=%b rdata=%h expected 0/0", dbg_ack_o, dbg_rdata_o);
    end
    for (int i = 0; i < 32; i++) begin
      rs1_addr_i = 5'(i);
      rs2_addr_i = 5'(31 - i);
      check_reads("reset_regs");
    end
  endtask
  task automatic test_wb_write();
    rd_we_i = 1'b1; rd_addr_i = 5; rd_data_i = 32'hDEADBEEF;
    cyc(); commit_wb(); rd_we_i = 1'b0;
    rs1_addr_i = 5; rs2_addr_i = 0;
    check_reads("wb_x5");
    vectors++;
    if (rs1_data_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wb_x5_const got %h expected deadbeef", rs1_data_o);
    end
    rd_we_i = 1'b1; rd_addr_i = 0; rd_data_i = 32'h1234;
    cyc(); commit_wb(); rd_we_i = 1'b0;
    rs1_addr_i = 0;
    check_reads("wb_x0");
    vectors++;
    if (rs1_data_o !== 32'h0) begin
      errors++;
      $display("FAIL x0_zero got %h expected 0", rs1_data_o);
    end
  endtask
  task automatic test_same_cycle();
    rd_we_i = 1'b1; rd_addr_i = 7; rd_data_i = 32'hA5A5A5A5;
    rs1_addr_i = 5; rs2_addr_i = 7;
    check_reads("same_cycle");
    cyc(); commit_wb(); rd_we_i = 1'b0;
    check_reads("after_same_cycle");
  endtask
  task automatic test_dbg_write_stall();
    int ack_cycle = -1;
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 10; dbg_wdata_i = 32'h55;
    rd_we_i = 1'b1; rd_addr_i = 11; rd_data_i = $urandom;
    for (int k = 1; k < 12 && ack_cycle < 0; k++) begin
      cyc(); commit_wb();
      if (dbg_ack_o) begin
        ack_cycle = k;
        dbg_req_i = 1'b0;
      end
      rd_we_i = k < 4;
      rd_addr_i = 5'(11 + k);
      rd_data_i = $urandom;
    end
    vectors++;
    if (ack_cycle != 5) begin
      errors++;
      $display("FAIL dbg_wr_stall ack cycle %0d expected 5", ack_cycle);
    end
    rd_we_i = 1'b0; dbg_req_i = 1'b0;
    cyc();
    vectors++;
    if (dbg_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL dbg_wr_ack_width ack=%b expected 0", dbg_ack_o);
    end
    model[10] = 32'h55;
    for (int i = 10; i < 16; i++) begin
      rs1_addr_i = 5'(i); rs2_addr_i = 5'(i + 1);
      check_reads("dbg_wr_regs");
    end
  endtask
  task automatic test_dbg_read();
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5;
    cyc();
    vectors++;
    if (dbg_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL dbg_rd_early ack=%b expected 0", dbg_ack_o);
    end
    cyc();
    vectors++;
    if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL dbg_rd_x5 ack=%b rdata=%h expected 1/deadbeef", dbg_ack_o, dbg_rdata_o);
    end
    dbg_req_i = 1'b0;
    cyc();
    vectors++;
    if (dbg_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL dbg_rd_ack_width ack=%b expected 0", dbg_ack_o);
    end
    dbg_req_i = 1'b1; dbg_addr_i = 5;
    cyc();
    rd_we_i = 1'b1; rd_addr_i = 5; rd_data_i = 32'hCAFEF00D;
    begin
      logic [31:0] exp = BYP ? 32'hCAFEF00D : model[5];
      cyc(); commit_wb(); rd_we_i = 1'b0;
      vectors++;
      if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== exp) begin
        errors++;
        $display("FAIL dbg_rd_collide ack=%b rdata=%h expected 1/%h", dbg_ack_o, dbg_rdata_o, exp);
      end
    end
    dbg_req_i = 1'b0;
    cyc();
  endtask
  task automatic dbg_txn(input logic we, input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    bit seen = 0;
    dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = d;
    while (!seen && n < 8) begin
      cyc();
      n++;
      if (dbg_ack_o) seen = 1;
    end
    vectors++;
    if (!seen || n != 2) begin
      errors++;
      $display("FAIL dbg_latency seen=%0d cycles=%0d expected 1/2", seen, n);
    end
    if (!we) begin
      vectors++;
      if (dbg_rdata_o !== model[a]) begin
        errors++;
        $display("FAIL dbg_rd[%0d] got %h expected %h", a, dbg_rdata_o, model[a]);
      end
    end else if (a != 0) model[a] = d;
    dbg_req_i = 1'b0;
    cyc();
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rd_we_i = 1'($urandom_range(0, 1));
      rd_addr_i = 5'($urandom);
      rd_data_i = $urandom;
      rs1_addr_i = $urandom_range(0, 3) == 0 ? rd_addr_i : 5'($urandom);
      rs2_addr_i = $urandom_range(0, 3) == 0 ? rd_addr_i : 5'($urandom);
      check_reads("rand_rd");
      cyc(); commit_wb();
    end
    rd_we_i = 1'b0;
    for (int i = 0; i < 40; i++) dbg_txn(1'($urandom_range(0, 1)), 5'($urandom), $urandom);
    for (int i = 0; i < 32; i++) begin
      rs1_addr_i = 5'(i); rs2_addr_i = 5'($urandom);
      check_reads("rand_final");
    end
  endtask
  task automatic test_reset_mid_access();
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; dbg_req_i = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (dbg_ack_o !== 1'b0 || dbg_rdata_o !== 32'h0) begin
        errors++;
        $display("FAIL rst_abort ack=%b rdata=%h expected 0/0", dbg_ack_o, dbg_rdata_o);
      end
      cyc();
    end
    for (int i = 0; i < 32; i++) begin
      rs1_addr_i = 5'(i); rs2_addr_i = 5'(31 - i);
      check_reads("rst_abort_regs");
    end
    dbg_txn(1'b0, 5'd5, 32'h0);
  endtask
  initial begin
    rst_n = 1'b0; rd_we_i = 1'b0; rd_addr_i = 0; rd_data_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = 0; dbg_wdata_i = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    cyc();
    test_reset();
    test_wb_write();
    test_same_cycle();
    test_dbg_write_stall();
    test_dbg_read();
    test_random();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
